// File: rtl/tbb_bus_pkg.sv
// Shared types and constants for the TBB1143 nibble-bus writer.
// Holds the sequencer state encoding, command field slices and the phase-counter width.
package tbb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STROBE,
        ST_ADDR_HOLD,
        ST_DATA_SETUP,
        ST_DATA_STROBE,
        ST_DATA_HOLD
    } state_t;

    localparam int REG_MSB = 7;
    localparam int REG_LSB = 4;
    localparam int VAL_MSB = 3;
    localparam int VAL_LSB = 0;
    localparam int CNT_W   = 4;

    // A phase lasting N cycles loads N-1 and leaves when the counter reads zero.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/tbb_cmd_fifo.sv
// Synchronous command FIFO with a show-ahead head word and a registered full flag.
// Pushes while full are dropped here, so the caller may drive push straight from valid.
module tbb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count, count_next;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count != '0);

    // NOTE: always_comb assigns a default before any branch so no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + LW'(1);
        else if (do_pop && !do_push)
            count_next = count - LW'(1);
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            full_q <= (count_next == LW'(DEPTH));
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = full_q;
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/tbb_bus_writer.sv
// Host-side sequencer: buffers byte commands and serialises each onto the TBB1143
// nibble bus as an optional address write followed by a data write, with programmable timing.
module tbb_bus_writer
    import tbb_bus_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SETUP          = 1,
    parameter int PULSE          = 2,
    parameter int HOLD           = 1,
    parameter int SKIP_SAME_ADDR = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 D,
    output logic                       A0,
    output logic                       WR,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam logic [CNT_W-1:0] LD_SETUP = phase_load(SETUP);
    localparam logic [CNT_W-1:0] LD_PULSE = phase_load(PULSE);
    localparam logic [CNT_W-1:0] LD_HOLD  = phase_load(HOLD);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cur;
    logic [7:0]       head;
    logic [3:0]       last_reg;
    logic             last_reg_valid;
    logic             full, empty, pop, skip;

    tbb_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Words are fetched from IDLE or on the final DATA_HOLD cycle, giving back-to-back transfers.
    assign pop  = !empty && ((state == ST_IDLE) || (state == ST_DATA_HOLD && cnt == '0));
    assign skip = (SKIP_SAME_ADDR != 0) && last_reg_valid && (head[REG_MSB:REG_LSB] == last_reg);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cur            <= '0;
            last_reg       <= '0;
            last_reg_valid <= 1'b0;
            D              <= '0;
            A0             <= 1'b0;
            WR             <= 1'b0;
        end else if (pop) begin
            cur <= head;
            cnt <= LD_SETUP;
            WR  <= 1'b0;
            if (skip) begin
                state <= ST_DATA_SETUP;
                A0    <= 1'b0;
                D     <= head[VAL_MSB:VAL_LSB];
            end else begin
                state <= ST_ADDR_SETUP;
                A0    <= 1'b1;
                D     <= head[REG_MSB:REG_LSB];
            end
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end else begin
            // WR only toggles on phase boundaries where D/A0 are held, so the core never sees them move.
            case (state)
                ST_ADDR_SETUP:  begin state <= ST_ADDR_STROBE; WR <= 1'b1; cnt <= LD_PULSE; end
                ST_ADDR_STROBE: begin state <= ST_ADDR_HOLD;   WR <= 1'b0; cnt <= LD_HOLD;  end
                ST_ADDR_HOLD: begin
                    state          <= ST_DATA_SETUP;
                    cnt            <= LD_SETUP;
                    A0             <= 1'b0;
                    D              <= cur[VAL_MSB:VAL_LSB];
                    last_reg       <= cur[REG_MSB:REG_LSB];
                    last_reg_valid <= 1'b1;
                end
                ST_DATA_SETUP:  begin state <= ST_DATA_STROBE; WR <= 1'b1; cnt <= LD_PULSE; end
                ST_DATA_STROBE: begin state <= ST_DATA_HOLD;   WR <= 1'b0; cnt <= LD_HOLD;  end
                ST_DATA_HOLD: begin
                    state <= ST_IDLE;
                    D     <= '0;
                    A0    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = !full;
    assign busy     = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_tbb_bus_writer.sv
// Self-checking bench: two writers (address skip on / off) checked cycle by cycle
// against a timeline model of the bus, plus directed scenarios and random traffic.
module tb_tbb_bus_writer;
    localparam int DEPTH = 4;
    localparam int S     = 1;
    localparam int P     = 2;
    localparam int H     = 1;
    localparam int T     = S + P + H;

    logic       CLK;
    logic       RST;
    logic [7:0] in_data  [2];
    logic       in_valid [2];
    logic       in_ready [2];
    logic [3:0] d        [2];
    logic       a0       [2];
    logic       wr       [2];
    logic       busy     [2];
    logic [2:0] level    [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int         pulses    [2];
    int         a0_pulses [2];
    int         max_lvl   [2];
    logic [3:0] data_q0 [$];
    logic [3:0] data_q1 [$];
    logic [3:0] addr_q1 [$];
    int         rise_q0 [$];

    tbb_bus_writer #(.DEPTH(DEPTH), .SETUP(S), .PULSE(P), .HOLD(H), .SKIP_SAME_ADDR(1)) dut0 (
        .CLK(CLK), .RST(RST), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .D(d[0]), .A0(a0[0]), .WR(wr[0]), .busy(busy[0]), .level(level[0])
    );

    tbb_bus_writer #(.DEPTH(DEPTH), .SETUP(S), .PULSE(P), .HOLD(H), .SKIP_SAME_ADDR(0)) dut1 (
        .CLK(CLK), .RST(RST), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .D(d[1]), .A0(a0[1]), .WR(wr[1]), .busy(busy[1]), .level(level[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected {WR, A0, D, level, busy, in_ready} from the position e inside the current word.
    function automatic logic [10:0] exp_vec(input bit act, input int e, input bit sk,
                                            input logic [3:0] r, input logic [3:0] v, input int lvl);
        logic       wr_e, a0_e;
        logic [3:0] d_e;
        int         t;
        wr_e = 1'b0; a0_e = 1'b0; d_e = 4'h0; t = e;
        if (act) begin
            if (!sk && t < T) begin
                a0_e = 1'b1;
                d_e  = r;
            end else begin
                if (!sk) t = t - T;
                d_e = v;
            end
            wr_e = (t >= S) && (t < S + P);
        end
        return {wr_e, a0_e, d_e, 3'(lvl), act || (lvl > 0), lvl < DEPTH};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam bit SK_EN = (g == 0);
        logic [7:0] q [$];
        bit         act    = 1'b0;
        int         rem    = 0;
        int         dur    = 0;
        bit         sk     = 1'b0;
        logic [3:0] r      = 4'h0;
        logic [3:0] v      = 4'h0;
        bit         last_v = 1'b0;
        logic [3:0] last_r = 4'h0;
        bit         prev_wr = 1'b0;

        always @(posedge CLK or negedge RST) begin
            bit         free, do_push, do_pop;
            logic [7:0] h;
            if (!RST) begin
                q.delete();
                act    = 1'b0;
                rem    = 0;
                last_v = 1'b0;
            end else begin
                free    = !act || (rem == 0);
                do_push = in_valid[g] && (q.size() < DEPTH);
                do_pop  = free && (q.size() > 0);
                if (do_pop) begin
                    h      = q.pop_front();
                    r      = h[7:4];
                    v      = h[3:0];
                    sk     = SK_EN && last_v && (r == last_r);
                    dur    = sk ? T : 2 * T;
                    rem    = dur - 1;
                    act    = 1'b1;
                    last_v = 1'b1;
                    last_r = r;
                end else if (free) begin
                    act = 1'b0;
                end else begin
                    rem = rem - 1;
                end
                if (do_push) q.push_back(in_data[g]);
            end
        end

        always @(posedge CLK) begin
            #1;
            check((g == 0) ? "bus0" : "bus1",
                  {wr[g], a0[g], d[g], level[g], busy[g], in_ready[g]},
                  exp_vec(act, dur - 1 - rem, sk, r, v, q.size()));
            if (int'(level[g]) > max_lvl[g]) max_lvl[g] = int'(level[g]);
            if (wr[g] && !prev_wr) begin
                pulses[g]++;
                if (a0[g]) a0_pulses[g]++;
                if (g == 0) begin
                    rise_q0.push_back(cyc);
                    if (!a0[g]) data_q0.push_back(d[g]);
                end else begin
                    if (a0[g]) addr_q1.push_back(d[g]);
                    else       data_q1.push_back(d[g]);
                end
            end
            prev_wr = wr[g];
        end
    end

    task automatic clear_stats();
        for (int g = 0; g < 2; g++) begin
            pulses[g] = 0; a0_pulses[g] = 0; max_lvl[g] = 0;
        end
        data_q0.delete(); data_q1.delete(); addr_q1.delete(); rise_q0.delete();
    endtask

    task automatic rst_dut();
        @(negedge CLK);
        RST = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        clear_stats();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int g, input logic [7:0] data, input bit hold_valid);
        int n = 0;
        in_data[g]  = data;
        in_valid[g] = 1'b1;
        while (!in_ready[g] && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("push_accept", 32'(n < 200), 1);
        @(negedge CLK);
        if (!hold_valid) in_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (busy[g] && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("idle_reached", 32'(n < 400), 1);
    endtask

    // seq lists expected nibbles most-significant first.
    task automatic check_seq(input string tag, input int which, input logic [31:0] seq, input int n);
        logic [3:0] got [$];
        case (which)
            0:       got = data_q0;
            1:       got = data_q1;
            default: got = addr_q1;
        endcase
        check({tag, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check(tag, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(seq[4*(n-1-i) +: 4]));
    endtask

    initial begin
        int k;
        int n;
        RST = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0;
            in_data[g]  = 8'h00;
        end
        clear_stats();
        @(negedge CLK);
        check("rst_bus", {wr[0], a0[0], d[0], level[0], busy[0], in_ready[0]}, 11'b0_0_0000_000_0_1);
        @(negedge CLK);
        RST = 1'b1;

        // Single write with default timing.
        rst_dut();
        push(0, 8'h3A, 1'b0);
        k = cyc;
        wait_idle(0);
        check("t1_idle_edge", 32'(cyc), 32'(k + 9));
        check("t1_pulses", 32'(pulses[0]), 2);
        check("t1_rise_addr", (rise_q0.size() > 0) ? 32'(rise_q0[0]) : 32'hDEAD, 32'(k + 2));
        check("t1_rise_data", (rise_q0.size() > 1) ? 32'(rise_q0[1]) : 32'hDEAD, 32'(k + 6));
        check_seq("t1_data", 0, 32'hA, 1);

        // Repeated register skips its address write: 0x35, 0x37 share reg 3.
        rst_dut();
        push(0, 8'h35, 1'b0);
        push(0, 8'h37, 1'b0);
        push(0, 8'h47, 1'b0);
        wait_idle(0);
        check("t2_pulses", 32'(pulses[0]), 5);
        check("t2_addr_pulses", 32'(a0_pulses[0]), 2);
        check_seq("t2_data", 0, 32'h577, 3);

        // Address skip disabled: each word gets its own address write.
        rst_dut();
        push(1, 8'h35, 1'b0);
        push(1, 8'h37, 1'b0);
        wait_idle(1);
        check("t3_pulses", 32'(pulses[1]), 4);
        check_seq("t3_addr", 2, 32'h33, 2);
        check_seq("t3_data", 1, 32'h57, 2);

        // Continuous offer of six words fills the FIFO; order must survive.
        rst_dut();
        push(0, 8'h10, 1'b1);
        push(0, 8'h21, 1'b1);
        push(0, 8'h32, 1'b1);
        push(0, 8'h43, 1'b1);
        push(0, 8'h54, 1'b1);
        push(0, 8'h65, 1'b0);
        wait_idle(0);
        check("t4_max_level", 32'(max_lvl[0]), 4);
        check_seq("t4_data", 0, 32'h012345, 6);

        // Offer while full: refused on the pop edge, taken on the next one.
        rst_dut();
        push(0, 8'h1A, 1'b1);
        push(0, 8'h2B, 1'b1);
        push(0, 8'h3C, 1'b1);
        push(0, 8'h4D, 1'b1);
        push(0, 8'h5E, 1'b1);
        check("t5_full_level", 32'(level[0]), 4);
        in_data[0] = 8'h6F;
        n = 0;
        while (level[0] == 3'd4 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("t5_pop_seen", 32'(n < 50), 1);
        check("t5_refused", {level[0], in_ready[0]}, {3'd3, 1'b1});
        @(negedge CLK);
        in_valid[0] = 1'b0;
        check("t5_accepted", 32'(level[0]), 4);
        wait_idle(0);
        check_seq("t5_data", 0, 32'hABCDEF, 6);

        // Reset during the address strobe abandons the transfer and forgets the last register.
        rst_dut();
        push(0, 8'h35, 1'b0);
        n = 0;
        while (!(wr[0] && a0[0]) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("t6_in_strobe", 32'(n < 50), 1);
        RST = 1'b0;
        #1;
        check("t6_rst_now", {wr[0], a0[0], d[0], level[0], busy[0], in_ready[0]}, 11'b0_0_0000_000_0_1);
        @(negedge CLK);
        RST = 1'b1;
        clear_stats();
        push(0, 8'h35, 1'b0);
        wait_idle(0);
        check("t6_no_skip_pulses", 32'(pulses[0]), 2);
        check("t6_addr_pulse", 32'(a0_pulses[0]), 1);

        // Random traffic on both writers, small register set to exercise skipping.
        rst_dut();
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < 2; g++) begin
                in_valid[g] = ($urandom_range(0, 2) == 0);
                in_data[g]  = {4'($urandom_range(0, 3)), 4'($urandom)};
            end
            @(negedge CLK);
        end
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        check("rand_max_level", 32'(max_lvl[0]), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
